// File: rtl/shift_pkg.sv
// Shared types for the shift command queue: command payload widths and the
// packed command record stored in each queue entry.
package shift_pkg;
  localparam int SHIFT_DW = 32;
  localparam int SHIFT_AW = 5;

  typedef struct packed {
    logic [SHIFT_DW-1:0] data;
    logic [SHIFT_AW-1:0] shift_amt;
    logic                direction;
  } shift_cmd_t;
endpackage

// File: rtl/shift_cmd_fifo_mem.sv
// Command storage: DEPTH entries, one synchronous write port and one
// asynchronous read port. Entries are not reset; the queue masks empty reads.
module shift_cmd_fifo_mem
  import shift_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  shift_cmd_t    wr_data,
  input  logic [AW-1:0] rd_addr,
  output shift_cmd_t    rd_data
);

  shift_cmd_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/shift_cmd_queue.sv
// Command queue in front of the barrel shifter: FIFO of shift commands with
// valid/ready handshakes on both sides, flush, and an issued-command counter.
module shift_cmd_queue
  import shift_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SHIFT_DW-1:0]        in_data,
  input  logic [SHIFT_AW-1:0]        in_shift_amt,
  input  logic                       in_direction,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [SHIFT_DW-1:0]        out_data,
  output logic [SHIFT_AW-1:0]        out_shift_amt,
  output logic                       out_direction,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNTW-1:0]            issued
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CNTW-1:0] issued_q, issued_d;
  logic            push, pop;
  shift_cmd_t      wr_cmd, rd_cmd;

  // Readiness depends only on occupancy, never on out_ready: a full queue
  // refuses a push even when a pop happens in the same cycle.
  assign in_ready  = !rst && (count_q < CW'(DEPTH)) && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_cmd = '{data: in_data, shift_amt: in_shift_amt, direction: in_direction};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    issued_d = issued_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        issued_d = issued_q + CNTW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      issued_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      issued_q <= issued_d;
    end
  end

  shift_cmd_fifo_mem #(.DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_cmd),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_cmd)
  );

  // Stale entry contents never reach the shifter while the queue is empty.
  assign out_data      = out_valid ? rd_cmd.data      : '0;
  assign out_shift_amt = out_valid ? rd_cmd.shift_amt : '0;
  assign out_direction = out_valid ? rd_cmd.direction : 1'b0;
  assign count         = count_q;
  assign issued        = issued_q;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Self-checking bench for shift_cmd_queue: directed table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_shift_cmd_queue;
  localparam int DEPTH = 8;
  localparam int CNTW  = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]     in_data = '0;
  logic [4:0]      in_shift_amt = '0;
  logic            in_direction = 1'b0;
  logic            in_ready, out_valid, out_direction;
  logic [31:0]     out_data;
  logic [4:0]      out_shift_amt;
  logic [CW-1:0]   count;
  logic [CNTW-1:0] issued;

  int n_pass = 0, n_total = 0;

  logic [37:0] mq[$];
  int unsigned miss = 0;

  always #5 clk = ~clk;

  shift_cmd_queue #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shift_amt(in_shift_amt), .in_direction(in_direction),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_shift_amt(out_shift_amt), .out_direction(out_direction),
    .count(count), .issued(issued)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock cycle: drive, check in_ready, clock, update model, check outputs.
  task automatic cyc(input bit r, input bit f, input bit iv, input logic [31:0] d,
                     input logic [4:0] a, input bit dir, input bit ordy);
    bit do_pop, do_push;
    logic [37:0] head;
    rst = r; flush = f; in_valid = iv; in_data = d; in_shift_amt = a;
    in_direction = dir; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !r && !f && (mq.size() < DEPTH));
    @(posedge clk);
    if (r) begin
      mq.delete();
      miss = 0;
    end else if (f) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && ordy;
      do_push = iv && (mq.size() < DEPTH);
      if (do_pop) begin
        void'(mq.pop_front());
        miss = (miss + 1) % (1 << CNTW);
      end
      if (do_push) mq.push_back({d, a, dir});
    end
    #1;
    chk("out_valid", out_valid, mq.size() != 0);
    chk("count", count, mq.size());
    chk("issued", issued, miss);
    if (mq.size() != 0) begin
      head = mq[0];
      chk("head", {out_data, out_shift_amt, out_direction}, head);
    end
  endtask

  typedef struct {
    bit r, f, iv;
    logic [31:0] d;
    logic [4:0] a;
    bit dir, ordy;
    bit e_ov;
    logic [31:0] e_d;
    logic [4:0] e_a;
    bit e_dir;
    int e_cnt, e_iss;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{1,0,0,32'h0,0,0,0,        0,32'h0,0,0,0,0};
    vt[1] = '{0,0,1,32'h0000_00F0,4,0,1, 1,32'h0000_00F0,4,0,1,0};
    vt[2] = '{0,0,0,32'h0,0,0,1,        0,32'h0,0,0,0,1};
    vt[3] = '{0,0,1,32'hAAAA_0001,3,1,0, 1,32'hAAAA_0001,3,1,1,1};
    vt[4] = '{0,0,1,32'hBBBB_0002,7,0,1, 1,32'hBBBB_0002,7,0,1,2};
    vt[5] = '{0,0,1,32'hCCCC_0003,31,1,0,1,32'hBBBB_0002,7,0,2,2};
    vt[6] = '{0,0,0,32'h0,0,0,0,        1,32'hBBBB_0002,7,0,2,2};
    vt[7] = '{0,1,1,32'hDEAD_BEEF,9,1,1, 0,32'h0,0,0,0,2};
    vt[8] = '{0,0,0,32'h0,0,0,1,        0,32'h0,0,0,0,2};

    for (int i = 0; i < 9; i++) begin
      cyc(vt[i].r, vt[i].f, vt[i].iv, vt[i].d, vt[i].a, vt[i].dir, vt[i].ordy);
      chk($sformatf("vec%0d_valid", i), out_valid, vt[i].e_ov);
      chk($sformatf("vec%0d_count", i), count, vt[i].e_cnt);
      chk($sformatf("vec%0d_issued", i), issued, vt[i].e_iss);
      if (vt[i].e_ov || vt[i].r)
        chk($sformatf("vec%0d_cmd", i), {out_data, out_shift_amt, out_direction},
            {vt[i].e_d, vt[i].e_a, vt[i].e_dir});
    end

    // Fill to full with out_ready low, refuse a 9th push, then drain in order.
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, i, 5'(i), i[0], 0);
    chk("full_count", count, DEPTH);
    chk("full_in_ready", in_ready, 0);
    cyc(0, 0, 1, 32'h99, 5'd9, 1, 0);
    chk("ninth_ignored_count", count, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", out_data, i);
      cyc(0, 0, 0, 0, 0, 0, 1);
    end
    chk("drained_count", count, 0);

    // Full queue with push and pop offered together: only the pop happens.
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 32'h100 + i, 5'(i), 0, 0);
    cyc(0, 0, 1, 32'h77, 5'd1, 1, 1);
    chk("full_pushpop_count", count, DEPTH - 1);
    chk("full_pushpop_head", out_data, 32'h101);

    // Pop down to 5 then flush while a push is offered.
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("pre_flush_count", count, 5);
    begin
      logic [CNTW-1:0] iss_before;
      iss_before = issued;
      chk("pre_flush_issued", iss_before, 11);
      cyc(0, 1, 1, 32'h55, 5'd2, 0, 1);
      chk("flush_count", count, 0);
      chk("flush_valid", out_valid, 0);
      chk("flush_issued", issued, 11);
    end

    // Randomized traffic.
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 3,
          $urandom_range(0, 9) < 7, $urandom, 5'($urandom), 1'($urandom),
          $urandom_range(0, 9) < 6);

    // Stream until issued reaches its maximum, then wrap it to zero.
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600 && miss != (1 << CNTW) - 1; i++)
      cyc(0, 0, 1, $urandom, 5'($urandom), 1'($urandom), 1);
    chk("issued_max", issued, (1 << CNTW) - 1);
    cyc(0, 0, 1, 32'h1234, 5'd3, 0, 1);
    chk("issued_wrap", issued, 0);

    // Reset mid-stream with three queued commands.
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h200 + i, 5'(i), 1, 0);
    chk("pre_rst_count", count, 3);
    cyc(1, 0, 1, 32'hF00D, 5'd1, 0, 1);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_issued", issued, 0);
    chk("rst_data", out_data, 0);
    cyc(0, 0, 1, 32'h0000_0ABC, 5'd6, 1, 0);
    chk("post_rst_push", out_data, 32'h0000_0ABC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/shift_cmd_queue.md
SHIFT_CMD_QUEUE -- requirements
Module: shift_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter CNTW, default 16, width of issued-command counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous queue clear.
REQ-006 SHALL have port in_valid  input  1  command offered.
REQ-007 SHALL have port in_ready  output  1  queue can accept.
REQ-008 SHALL have port in_data  input  32  operand.
REQ-009 SHALL have port in_shift_amt  input  5  shift amount.
REQ-010 SHALL have port in_direction  input  1  0=left, 1=right.
REQ-011 SHALL have port out_ready  input  1  downstream shifter may take a command this cycle.
REQ-012 SHALL have port out_valid  output  1  drives shifter valid_in.
REQ-013 SHALL have port out_data  output  32  drives shifter data_in.
REQ-014 SHALL have port out_shift_amt  output  5  drives shifter shift_amt.
REQ-015 SHALL have port out_direction  output  1  drives shifter direction.
REQ-016 SHALL have port count  output  $clog2(DEPTH+1)  entries held, including the presented head.
REQ-017 SHALL have port issued  output  CNTW  commands issued, wraps modulo 2^CNTW.

Function
REQ-018 Push SHALL occur when in_valid && in_ready; pop when out_valid && out_ready.
REQ-019 in_ready SHALL equal (count < DEPTH) && !flush; independent of out_ready (no same-cycle pass-through when full).
REQ-020 out_valid SHALL equal (count != 0); out_data/out_shift_amt/out_direction SHALL be the oldest entry, FIFO order.
REQ-021 Latency: command pushed at edge N into empty queue SHALL appear with out_valid=1 after edge N (visible in cycle N+1).
REQ-022 While out_valid && !out_ready, all out_* SHALL be held stable.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including at count=1 (new entry becomes head next cycle) and count=DEPTH-1.
REQ-024 count SHALL reach exactly DEPTH when full, 0 when empty; never over/underflow.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH without gaps.
REQ-026 issued SHALL increment by 1 on each pop, wrapping 2^CNTW-1 -> 0.
REQ-027 flush=1 SHALL at the edge set count=0, pointers=0, out_valid=0; push and pop that cycle SHALL be discarded; issued unchanged.
REQ-028 in_data etc. SHALL be ignored when push is not accepted; contents of unused entries SHALL not affect outputs.

Reset
REQ-029 rst=1 at an edge SHALL set count=0, pointers=0, issued=0, out_valid=0, out_data=0, out_shift_amt=0, out_direction=0, in_ready=0 during the reset cycle.
REQ-030 rst SHALL have priority over flush, push and pop; reset mid-stream SHALL drop all queued commands.
REQ-031 First push SHALL be accepted in the cycle after rst deasserts.

Structure
REQ-032 Package shift_pkg SHALL hold SHIFT_DW=32, SHIFT_AW=5, and struct shift_cmd_t {data, shift_amt, direction} (38 bits).
REQ-033 Storage SHALL be a sub-module shift_cmd_fifo_mem (DEPTH x shift_cmd_t, one write port, one async read port); control and counters stay in shift_cmd_queue.
REQ-034 All outputs except in_ready, out_valid SHALL come directly from registers or the memory read of a registered pointer; no combinational input-to-output path except none.

Verification
REQ-035 Reset, then push {0x0000_00F0, 4, L} with out_ready=1 -> next cycle out_valid=1, out_data=0x0000_00F0, amt=4, dir=0; issued=1 after the pop edge.
REQ-036 out_ready=0, push 8 commands 0..7 -> count=8, in_ready=0; 9th push ignored; out_ready=1 -> commands 0..7 emitted in order, one per cycle, count back to 0.
REQ-037 Full queue, in_valid=1 and out_ready=1 same cycle -> pop accepted, push refused, count=7.
REQ-038 count=1, simultaneous push/pop -> count stays 1, next head is new command.
REQ-039 count=5, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, issued unchanged.
REQ-040 Preload issued to 0xFFFF via 65535 pops (or forced), one more pop -> issued=0x0000; rst mid-stream with count=3 -> count=0, out_valid=0, issued=0.
